// File: rtl/mcl_regfile_node.sv
// mcl_regfile_node
//   Endpoint for one MCL/FSB channel. Each 80-bit request packet is decoded as a
//   read or a write to a local 32-bit register file. Exactly one 80-bit response
//   is queued per accepted request in a circular response FIFO, and the FIFO head
//   is returned to the bridge.
//
//   Request packet : [79:72] opcode (01 write, 02 read) [71:64] tag
//                    [63:32] addr (word index)          [31:0]  wdata
//   Response packet: [79:72] status (00 ok, 0E out of range, EE illegal opcode)
//                    [71:64] tag  [63:32] addr  [31:0] data
//
//   Handshakes:
//     request  : accepted on a rising edge where v_i & ready_o. ready_o depends
//                only on en_i, reset and the registered FIFO count, never on
//                v_i, data_i or yumi_i.
//     response : v_o is high whenever the FIFO holds an entry and data_o is the
//                head; yumi_i pops the head and may only be raised while v_o=1.
//
//   Ports:
//     clk_main_a0  clock
//     rst_main_n   asynchronous active-low reset
//     en_i         enable; 0 blocks new requests, queued responses still drain
//     v_i, data_i  request valid / packet
//     ready_o      node can accept a request
//     v_o, data_o  response valid / packet (FIFO head)
//     yumi_i       consumer takes the response
//
//   Optional feature (macro MCL_REGFILE_NODE_STATS_EN):
//     32-bit saturating counters req_cnt (accepted requests) and err_cnt
//     (responses with status 0E or EE). Address 32'hFFFF_FFF0 reads req_cnt,
//     32'hFFFF_FFF1 reads err_cnt; a write to either clears that counter.
//     Without the macro these addresses are simply out of range.

module mcl_regfile_node #(
  parameter int data_width_p    = 80,
  parameter int els_p           = 16,
  parameter int resp_fifo_els_p = 4
) (
  input  logic                    clk_main_a0,
  input  logic                    rst_main_n,
  input  logic                    en_i,
  input  logic                    v_i,
  input  logic [data_width_p-1:0] data_i,
  output logic                    ready_o,
  output logic                    v_o,
  output logic [data_width_p-1:0] data_o,
  input  logic                    yumi_i
);

  // Elaboration-time parameter checks.
  if (data_width_p != 80) begin : g_bad_width
    $error("mcl_regfile_node: data_width_p must be 80");
  end
  if ((els_p < 2) || (els_p > 256) || ((els_p & (els_p - 1)) != 0)) begin : g_bad_els
    $error("mcl_regfile_node: els_p must be a power of two in 2..256");
  end
  if ((resp_fifo_els_p < 2) || ((resp_fifo_els_p & (resp_fifo_els_p - 1)) != 0)) begin : g_bad_fifo
    $error("mcl_regfile_node: resp_fifo_els_p must be a power of two >= 2");
  end

  localparam int addr_w_lp = $clog2(els_p);
  localparam int ptr_w_lp  = $clog2(resp_fifo_els_p);

  localparam logic [7:0] op_write_c   = 8'h01;
  localparam logic [7:0] op_read_c    = 8'h02;
  localparam logic [7:0] st_ok_c      = 8'h00;
  localparam logic [7:0] st_range_c   = 8'h0E;
  localparam logic [7:0] st_illegal_c = 8'hEE;

  localparam logic [ptr_w_lp:0] full_c = (ptr_w_lp+1)'(resp_fifo_els_p);

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic [7:0]  req_op;
  logic [7:0]  req_tag;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        in_range;
  logic [addr_w_lp-1:0] reg_idx;

  assign req_op    = data_i[79:72];
  assign req_tag   = data_i[71:64];
  assign req_addr  = data_i[63:32];
  assign req_wdata = data_i[31:0];
  assign in_range  = (req_addr < 32'(els_p));
  assign reg_idx   = req_addr[addr_w_lp-1:0];

  logic [31:0] reg_mem [els_p];
  logic [data_width_p-1:0] fifo_mem [resp_fifo_els_p];
  logic [ptr_w_lp-1:0] rd_ptr;
  logic [ptr_w_lp-1:0] wr_ptr;
  logic [ptr_w_lp:0]   count;

  logic accept;
  logic pop;

  // Reset is folded in so ready_o is low for the whole time reset is held,
  // even though the count already reads zero.
  assign ready_o = rst_main_n & en_i & (count != full_c);
  assign v_o     = (count != '0);
  assign data_o  = fifo_mem[rd_ptr];
  assign accept  = v_i & ready_o;
  // A yumi_i on an empty FIFO is dropped here so the pointers never move.
  assign pop     = yumi_i & v_o;

`ifdef MCL_REGFILE_NODE_STATS_EN
  localparam logic [31:0] req_cnt_addr_c = 32'hFFFF_FFF0;
  localparam logic [31:0] err_cnt_addr_c = 32'hFFFF_FFF1;
  logic [31:0] req_cnt;
  logic [31:0] err_cnt;
  logic        clr_req;
  logic        clr_err;
`endif

  logic [7:0]  resp_status;
  logic [31:0] resp_data;
  logic        reg_we;
  logic [data_width_p-1:0] resp_pkt;

  always_comb begin
    resp_status = st_illegal_c;
    resp_data   = '0;
    reg_we      = 1'b0;
`ifdef MCL_REGFILE_NODE_STATS_EN
    clr_req     = 1'b0;
    clr_err     = 1'b0;
`endif
    case (req_op)
      op_write_c: begin
        if (in_range) begin
          resp_status = st_ok_c;
          resp_data   = req_wdata;
          reg_we      = 1'b1;
        end
`ifdef MCL_REGFILE_NODE_STATS_EN
        else if (req_addr == req_cnt_addr_c) begin
          resp_status = st_ok_c;
          resp_data   = req_wdata;
          clr_req     = 1'b1;
        end else if (req_addr == err_cnt_addr_c) begin
          resp_status = st_ok_c;
          resp_data   = req_wdata;
          clr_err     = 1'b1;
        end
`endif
        else begin
          resp_status = st_range_c;
        end
      end
      op_read_c: begin
        // Register value before any write on this edge; only one request per
        // cycle so there is never a same-cycle write to the same word.
        if (in_range) begin
          resp_status = st_ok_c;
          resp_data   = reg_mem[reg_idx];
        end
`ifdef MCL_REGFILE_NODE_STATS_EN
        else if (req_addr == req_cnt_addr_c) begin
          resp_status = st_ok_c;
          resp_data   = req_cnt;
        end else if (req_addr == err_cnt_addr_c) begin
          resp_status = st_ok_c;
          resp_data   = err_cnt;
        end
`endif
        else begin
          resp_status = st_range_c;
        end
      end
      default: begin
        resp_status = st_illegal_c;
      end
    endcase
  end

  assign resp_pkt = {resp_status, req_tag, req_addr, resp_data};

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      for (int i = 0; i < els_p; i++) begin
        reg_mem[i] <= '0;
      end
    end else if (accept && reg_we) begin
      reg_mem[reg_idx] <= req_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Response FIFO (circular buffer, count carries one extra bit for full)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < resp_fifo_els_p; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      if (accept) begin
        fifo_mem[wr_ptr] <= resp_pkt;
        wr_ptr           <= wr_ptr + ptr_w_lp'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ptr_w_lp'(1);
      end
      case ({accept, pop})
        2'b10:   count <= count + (ptr_w_lp+1)'(1);
        2'b01:   count <= count - (ptr_w_lp+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef MCL_REGFILE_NODE_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics counters. A request reading a counter sees the value before its
  // own increment. A clearing write zeroes the counter and is then counted
  // itself, so req_cnt restarts at 1 after a clear.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      req_cnt <= '0;
      err_cnt <= '0;
    end else if (accept) begin
      if (clr_req) begin
        req_cnt <= 32'd1;
      end else if (req_cnt != '1) begin
        req_cnt <= req_cnt + 32'd1;
      end
      if (clr_err) begin
        err_cnt <= '0;
      end else if ((resp_status != st_ok_c) && (err_cnt != '1)) begin
        err_cnt <= err_cnt + 32'd1;
      end
    end
  end
`endif

  // Consumer must not take a response that is not there.
  yumi_only_when_valid: assert property (
    @(posedge clk_main_a0) disable iff (!rst_main_n) yumi_i |-> v_o
  );

endmodule

// File: tb/tb_mcl_regfile_node.sv
module tb_mcl_regfile_node;

  localparam int ELS  = 16;
  localparam int FDEP = 4;

  logic        clk_main_a0;
  logic        rst_main_n;
  logic        en_i;
  logic        v_i;
  logic [79:0] data_i;
  logic        ready_o;
  logic        v_o;
  logic [79:0] data_o;
  logic        yumi_i;

  mcl_regfile_node #(
    .data_width_p   (80),
    .els_p          (ELS),
    .resp_fifo_els_p(FDEP)
  ) dut (
    .clk_main_a0(clk_main_a0),
    .rst_main_n (rst_main_n),
    .en_i       (en_i),
    .v_i        (v_i),
    .data_i     (data_i),
    .ready_o    (ready_o),
    .v_o        (v_o),
    .data_o     (data_o),
    .yumi_i     (yumi_i)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk_main_a0 = 1'b0;
  always #5 clk_main_a0 = ~clk_main_a0;

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------------
  logic [79:0] exp_q[$];
  logic [31:0] m_regs [ELS];
  logic [31:0] m_req;
  logic [31:0] m_err;

  int n_vec;
  int n_err;

  // DUT-side observations of the last step
  logic        dut_acc;
  logic        dut_pop;
  logic [79:0] seen;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [79:0] mk(input logic [7:0] op, input logic [7:0] tag,
                                     input logic [31:0] addr, input logic [31:0] wd);
    return {op, tag, addr, wd};
  endfunction

  // Applies one request to the model state and returns the response packet.
  function automatic logic [79:0] model_apply(input logic [79:0] pkt);
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [7:0]  st;
    logic [31:0] rd;
    bit          clr_r;
    bit          clr_e;
    op    = pkt[79:72];
    addr  = pkt[63:32];
    wd    = pkt[31:0];
    st    = 8'hEE;
    rd    = 32'h0;
    clr_r = 0;
    clr_e = 0;
    if (op == 8'h01 || op == 8'h02) begin
      if (addr < ELS) begin
        st = 8'h00;
        if (op == 8'h01) begin
          m_regs[addr] = wd;
          rd = wd;
        end else begin
          rd = m_regs[addr];
        end
      end
`ifdef MCL_REGFILE_NODE_STATS_EN
      else if (addr == 32'hFFFF_FFF0 || addr == 32'hFFFF_FFF1) begin
        st = 8'h00;
        if (op == 8'h01) begin
          rd = wd;
          if (addr == 32'hFFFF_FFF0) clr_r = 1; else clr_e = 1;
        end else begin
          rd = (addr == 32'hFFFF_FFF0) ? m_req : m_err;
        end
      end
`endif
      else begin
        st = 8'h0E;
      end
    end
    if (clr_r) m_req = 32'd1;
    else if (m_req != 32'hFFFF_FFFF) m_req = m_req + 1;
    if (clr_e) m_err = 32'd0;
    else if (st != 8'h00 && m_err != 32'hFFFF_FFFF) m_err = m_err + 1;
    return {st, pkt[71:64], addr, rd};
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    for (int i = 0; i < ELS; i++) m_regs[i] = 32'h0;
    m_req = 32'h0;
    m_err = 32'h0;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: called at posedge+1. Drives one cycle, checks outputs at negedge
  // against the model, then advances the model to match the coming edge.
  // ---------------------------------------------------------------------------
  task automatic step(input logic v, input logic [79:0] d, input logic y_req);
    logic exp_ready;
    logic m_acc;
    logic m_pop;
    v_i    = v;
    data_i = d;
    yumi_i = y_req && (exp_q.size() != 0);
    @(negedge clk_main_a0);
    exp_ready = en_i && (exp_q.size() < FDEP);
    chk("ready_o", 80'(ready_o), 80'(exp_ready));
    chk("v_o", 80'(v_o), 80'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk("data_o", data_o, exp_q[0]);
    seen    = data_o;
    dut_acc = v && ready_o;
    dut_pop = yumi_i && v_o;
    m_acc   = v && exp_ready;
    m_pop   = yumi_i;
    if (m_pop) void'(exp_q.pop_front());
    if (m_acc) exp_q.push_back(model_apply(d));
    @(posedge clk_main_a0);
    #1;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 40) begin
      step(1'b0, 80'h0, 1'b1);
      guard++;
    end
    chk("drain_bound", 80'(exp_q.size()), 80'(0));
  endtask

  task automatic do_reset();
    rst_main_n = 1'b0;
    v_i        = 1'b0;
    yumi_i     = 1'b0;
    data_i     = '0;
    #1;
    chk("rst_v_o", 80'(v_o), 80'(0));
    chk("rst_data_o", data_o, 80'h0);
    chk("rst_ready_o", 80'(ready_o), 80'(0));
    model_reset();
    repeat (2) @(posedge clk_main_a0);
    #1;
    rst_main_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [7:0]  op;
    logic [7:0]  tag;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  exp_st;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl[10];

  int n_acc;
  int n_pop;

  initial begin
    n_vec  = 0;
    n_err  = 0;
    en_i   = 1'b1;
    v_i    = 1'b0;
    yumi_i = 1'b0;
    data_i = '0;
    rst_main_n = 1'b0;

    tbl[0] = '{8'h01, 8'h05, 32'd3,          32'hDEADBEEF, 8'h00, 32'hDEADBEEF};
    tbl[1] = '{8'h02, 8'h06, 32'd3,          32'h0,        8'h00, 32'hDEADBEEF};
    tbl[2] = '{8'h02, 8'h07, 32'd16,         32'h0,        8'h0E, 32'h0};
    tbl[3] = '{8'h7F, 8'h08, 32'd3,          32'h1234,     8'hEE, 32'h0};
    tbl[4] = '{8'h01, 8'h09, 32'd15,         32'hA5A50001, 8'h00, 32'hA5A50001};
    tbl[5] = '{8'h02, 8'h0A, 32'd15,         32'h0,        8'h00, 32'hA5A50001};
    tbl[6] = '{8'h01, 8'h0B, 32'h0001_0003,  32'h77,       8'h0E, 32'h0};
    tbl[7] = '{8'h02, 8'h0C, 32'd3,          32'h0,        8'h00, 32'hDEADBEEF};
    tbl[8] = '{8'h00, 8'h0D, 32'd0,          32'h55,       8'hEE, 32'h0};
    tbl[9] = '{8'h01, 8'h0E, 32'd0,          32'h1,        8'h00, 32'h1};

    do_reset();

    // Table: one request, then take its response on the following cycle.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, mk(tbl[i].op, tbl[i].tag, tbl[i].addr, tbl[i].wdata), 1'b0);
      step(1'b0, 80'h0, 1'b1);
      chk($sformatf("tbl%0d", i), seen,
          {tbl[i].exp_st, tbl[i].tag, tbl[i].addr, tbl[i].exp_data});
    end

    // All 16 registers after the illegal-opcode request: only 0, 3, 15 written.
    for (int i = 0; i < ELS; i++) begin
      step(1'b1, mk(8'h02, 8'(i), 32'(i), 32'h0), 1'b0);
      step(1'b0, 80'h0, 1'b1);
    end

    // Back-to-back write then read of the same address.
    step(1'b1, mk(8'h01, 8'h20, 32'd7, 32'hCAFE0007), 1'b0);
    step(1'b1, mk(8'h02, 8'h21, 32'd7, 32'h0), 1'b1);
    drain();

    // Backpressure: six requests with yumi held low, only four fit.
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, mk(8'h02, 8'(i), 32'(i), 32'h0), 1'b0);
      if (dut_acc) n_acc++;
    end
    chk("bp_accepted", 80'(n_acc), 80'(4));
    drain();

    // Streaming: one primed entry, then 50 cycles of push and pop together.
    step(1'b1, mk(8'h01, 8'h40, 32'd0, 32'h1000), 1'b0);
    n_pop = 0;
    for (int i = 0; i < 50; i++) begin
      step(1'b1, mk(8'h01, 8'(8'h41 + i), 32'(i % ELS), 32'h2000 + 32'(i)), 1'b1);
      if (dut_pop) n_pop++;
    end
    chk("stream_pops", 80'(n_pop), 80'(50));
    drain();

    // Random traffic including en_i drops and protocol-legal yumi.
    for (int i = 0; i < 400; i++) begin
      logic [7:0]  op;
      logic [31:0] addr;
      int          r;
      en_i = ($urandom_range(0, 9) != 0);
      r = $urandom_range(0, 9);
      op = (r < 4) ? 8'h01 : (r < 8) ? 8'h02 : 8'($urandom);
      addr = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(0, 19));
      step($urandom_range(0, 9) < 7, mk(op, 8'($urandom), addr, 32'($urandom)),
           $urandom_range(0, 9) < 6);
    end
    en_i = 1'b1;
    drain();

    // Reset mid-operation with three responses queued.
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, mk(8'h01, 8'(8'h60 + i), 32'(i), 32'h1111_0000 + 32'(i)), 1'b0);
    end
    chk("pre_rst_queued", 80'(exp_q.size()), 80'(3));
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, mk(8'h02, 8'(8'h70 + i), 32'(i), 32'h0), 1'b0);
      step(1'b0, 80'h0, 1'b1);
      chk($sformatf("post_rst_rd%0d", i), 80'(seen[31:0]), 80'(0));
    end

`ifdef MCL_REGFILE_NODE_STATS_EN
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, mk(8'h01, 8'(i), 32'(i), 32'h5), 1'b0);
      step(1'b0, 80'h0, 1'b1);
    end
    step(1'b1, mk(8'h02, 8'h90, 32'hFFFF_FFF0, 32'h0), 1'b0);
    step(1'b0, 80'h0, 1'b1);
    chk("stats_req3", 80'(seen[31:0]), 80'(3));
    step(1'b1, mk(8'h01, 8'h91, 32'hFFFF_FFF0, 32'h0), 1'b0);
    step(1'b0, 80'h0, 1'b1);
    step(1'b1, mk(8'h02, 8'h92, 32'hFFFF_FFF0, 32'h0), 1'b0);
    step(1'b0, 80'h0, 1'b1);
    chk("stats_req_after_clr", 80'(seen[31:0]), 80'(1));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
